// File: rtl/mult_rr_scheduler.sv
// Round-robin front end that shares one external multiplier among NREQ requesters.
// One operation in flight; timeout aborts a stuck multiplier with resp_error.
module mult_rr_scheduler #(
   parameter int N       = 64,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [2*N-1:0]    resp_product,
   output logic              resp_error,
   output logic              mul_init,
   output logic [N-1:0]      mul_multiplicand,
   output logic [N-1:0]      mul_multiplier,
   input  logic              mul_idle,
   input  logic              mul_valid,
   input  logic [2*N-1:0]    mul_product,
   output logic              busy
);
   localparam int GW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   rr_ptr, grant, pick;
   logic [GW:0]     idx;
   logic            pick_vld, take;
   logic [7:0]      cnt, cnt_inc;
   logic            err;
   logic [NREQ-1:0] gmask;

   // Descending scan so the lowest offset from rr_ptr wins without a break.
   always_comb begin
      idx      = '0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = NREQ-1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (GW+1)'(k);
         if (idx >= (GW+1)'(NREQ)) idx = idx - (GW+1)'(NREQ);
         if (req_valid[idx[GW-1:0]]) begin
            pick     = idx[GW-1:0];
            pick_vld = 1'b1;
         end
      end
   end

   assign take    = (state == IDLE) && mul_idle && pick_vld;
   assign cnt_inc = cnt + 8'd1;
   assign gmask   = {{(NREQ-1){1'b0}}, 1'b1} << grant;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (mul_valid || cnt_inc == 8'(TIMEOUT)) state_nxt = RESP;
         RESP:    if (resp_ready[grant]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         grant            <= '0;
         cnt              <= '0;
         err              <= 1'b0;
         mul_multiplicand <= '0;
         mul_multiplier   <= '0;
         resp_product     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (take) begin
               grant            <= pick;
               mul_multiplicand <= req_a[int'(pick)*N +: N];
               mul_multiplier   <= req_b[int'(pick)*N +: N];
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               if (mul_valid) begin
                  resp_product <= mul_product;
                  err          <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == 8'(TIMEOUT)) begin
                     resp_product <= '0;
                     err          <= 1'b1;
                  end
               end
            end
            RESP: if (resp_ready[grant])
               rr_ptr <= (grant == GW'(NREQ-1)) ? '0 : grant + GW'(1);
            default: ;
         endcase
      end
   end

   assign busy       = (state != IDLE);
   assign mul_init   = (state == ISSUE);
   assign req_ready  = (state == ISSUE) ? gmask : '0;
   assign resp_valid = (state == RESP) ? gmask : '0;
   assign resp_error = err && (state == RESP);

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: behavioural multiplier, round-robin reference and
// directed/randomized scenarios on a default instance plus a TIMEOUT=8 instance.
module tb_mult_rr_scheduler;
   localparam int N = 64;
   localparam int NREQ = 4;

   logic         clk, reset_L;
   logic [3:0]   req_valid, req_ready, resp_valid, resp_ready;
   logic [255:0] req_a, req_b;
   logic [127:0] resp_product, mul_product;
   logic         resp_error, mul_init, mul_idle, mul_valid, busy;
   logic [63:0]  mul_multiplicand, mul_multiplier;

   logic [3:0]   t_req_valid, t_req_ready, t_resp_valid, t_resp_ready;
   logic [31:0]  t_req_a, t_req_b;
   logic [15:0]  t_resp_product;
   logic         t_resp_error, t_mul_init, t_busy;
   logic [7:0]   t_mul_a, t_mul_b;

   int n_pass = 0, n_total = 0;
   int ref_ptr = 0, gwait = 0, mul_lat = 3;
   int rem = 0;
   logic [63:0] op_a = '0, op_b = '0;
   logic model_valid = 1'b0, spurious = 1'b0, idle_en = 1'b1;

   mult_rr_scheduler u_dut (
      .clk(clk), .reset_L(reset_L), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_product(resp_product), .resp_error(resp_error), .mul_init(mul_init),
      .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
      .mul_idle(mul_idle), .mul_valid(mul_valid), .mul_product(mul_product), .busy(busy));

   mult_rr_scheduler #(.N(8), .NREQ(4), .TIMEOUT(8)) u_to (
      .clk(clk), .reset_L(reset_L), .req_valid(t_req_valid), .req_ready(t_req_ready),
      .req_a(t_req_a), .req_b(t_req_b), .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
      .resp_product(t_resp_product), .resp_error(t_resp_error), .mul_init(t_mul_init),
      .mul_multiplicand(t_mul_a), .mul_multiplier(t_mul_b),
      .mul_idle(1'b1), .mul_valid(1'b0), .mul_product(16'h0), .busy(t_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] sa, sb;
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      return sa * sb;
   endfunction

   function automatic int rr_pick(input logic [3:0] m, input int p);
      for (int k = 0; k < NREQ; k++)
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // Multiplier model: product appears mul_lat cycles after mul_init; 0 means never.
   always @(posedge clk) begin
      model_valid <= 1'b0;
      if (mul_init) begin
         rem  <= mul_lat;
         op_a <= mul_multiplicand;
         op_b <= mul_multiplier;
      end else if (rem > 0) begin
         rem <= rem - 1;
         if (rem == 1) begin
            model_valid <= 1'b1;
            mul_product <= smul(op_a, op_b);
         end
      end
   end
   assign mul_valid = model_valid | spurious;
   assign mul_idle  = idle_en && (rem == 0) && !model_valid;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Serve one operation for the main instance, checking grant, result and hold behaviour.
   task automatic serve(input int hold);
      int g, t, oth;
      logic [3:0] gm;
      logic [127:0] exp_p;
      g  = rr_pick(req_valid, ref_ptr);
      gm = (g < 0) ? 4'b0 : 4'(1 << g);
      t  = 0;
      while (req_ready === 4'b0 && t < 100) begin @(negedge clk); t++; end
      gwait = t;
      chk("grant", req_ready, gm);
      chk("mul_init", mul_init, 1);
      if (g < 0) return;
      exp_p = smul(req_a[g*64 +: 64], req_b[g*64 +: 64]);
      req_valid[g] = 1'b0;
      req_a[g*64 +: 64] = {$urandom, $urandom};
      req_b[g*64 +: 64] = {$urandom, $urandom};
      if ($urandom_range(3) == 0) begin
         oth = $urandom_range(3);
         if (oth != g) req_valid[oth] = 1'b0;
      end
      t = 0;
      while (resp_valid === 4'b0 && t < 400) begin @(negedge clk); t++; end
      if (mul_lat > 0) chk("latency", t, mul_lat + 2);
      chk("resp_valid", resp_valid, gm);
      chk("resp_product", resp_product, exp_p);
      chk("resp_error", resp_error, 0);
      repeat (hold) begin
         resp_ready = 4'($urandom) & ~gm;
         @(negedge clk);
         chk("hold_valid", resp_valid, gm);
         chk("hold_product", resp_product, exp_p);
         chk("hold_no_grant", req_ready, 0);
      end
      resp_ready = gm;
      @(negedge clk);
      resp_ready = 4'b0;
      chk("ack_valid", resp_valid, 0);
      chk("ack_busy", busy, 0);
      ref_ptr = (g + 1) % NREQ;
   endtask

   initial begin
      int t, cnt;
      reset_L = 1'b0; req_valid = 4'b0; resp_ready = 4'b0;
      req_a = '0; req_b = '0;
      t_req_valid = 4'b0; t_resp_ready = 4'b0; t_req_a = '0; t_req_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mul_init", mul_init, 0);
      chk("rst_operands", {mul_multiplicand, mul_multiplier}, 0);
      chk("rst_product", {resp_product, 7'b0, resp_error}, 0);

      // Contention from reset: first grant on first edge, then strict rotation.
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*64 +: 64] = {$urandom, $urandom};
         req_b[i*64 +: 64] = {$urandom, $urandom};
      end
      req_valid = 4'b1111;
      reset_L = 1'b1;
      for (int i = 0; i < 5; i++) begin
         serve(0);
         if (i == 0) chk("first_grant_edge", gwait, 1);
         req_valid = 4'b1111;
      end
      req_valid = 4'b0;
      @(negedge clk);

      // Single request, signed operands, slow multiplier.
      mul_lat = 66;
      req_a[64 +: 64] = 64'd3;
      req_b[64 +: 64] = -64'sd5;
      req_valid = 4'b0010;
      serve(0);
      chk("neg15", mul_product, -128'sd15);

      // Randomized masks, latencies and backpressure.
      for (int it = 0; it < 10; it++) begin
         if (req_valid == 4'b0) begin
            req_valid = 4'($urandom_range(15, 1));
            for (int i = 0; i < NREQ; i++) begin
               req_a[i*64 +: 64] = {$urandom, $urandom};
               req_b[i*64 +: 64] = {$urandom, $urandom};
            end
         end
         mul_lat = $urandom_range(20, 1);
         serve((it == 3) ? 10 : $urandom_range(4));
      end
      req_valid = 4'b0;
      @(negedge clk);

      // Multiplier busy holds off grants; grant on the first edge it is idle.
      mul_lat = 2;
      idle_en = 1'b0;
      req_valid = 4'b0001;
      repeat (5) begin
         @(negedge clk);
         chk("hold_off", {busy, req_ready}, 0);
      end
      idle_en = 1'b1;
      serve(0);
      chk("idle_grant_edge", gwait, 1);

      // mul_valid outside WAIT is ignored.
      spurious = 1'b1;
      @(negedge clk);
      spurious = 1'b0;
      @(negedge clk);
      chk("spurious", {busy, resp_valid}, 0);

      // Reset during WAIT abandons the operation.
      mul_lat = 40;
      req_valid = 4'b0100;
      t = 0;
      while (req_ready === 4'b0 && t < 50) begin @(negedge clk); t++; end
      chk("rst_op_grant", req_ready, 4'b0100);
      req_valid = 4'b0;
      repeat (5) @(negedge clk);
      reset_L = 1'b0;
      @(negedge clk);
      chk("rst_mid", {busy, req_ready, resp_valid, mul_init, resp_error}, 0);
      @(negedge clk);
      reset_L = 1'b1;
      ref_ptr = 0;
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (resp_valid !== 4'b0 || busy !== 1'b0) cnt++;
      end
      chk("rst_no_resp", cnt, 0);
      mul_lat = 3;
      req_valid = 4'b1111;
      serve(0);
      req_valid = 4'b0;
      @(negedge clk);

      // Timeout instance: never-valid multiplier aborts after 8 WAIT cycles.
      t_req_a = $urandom;
      t_req_b = $urandom;
      for (int op = 0; op < 2; op++) begin
         t_req_valid = (op == 0) ? 4'b0001 : 4'b0011;
         t = 0;
         while (t_req_ready === 4'b0 && t < 20) begin @(negedge clk); t++; end
         chk("to_grant", t_req_ready, (op == 0) ? 4'b0001 : 4'b0010);
         chk("to_mul_init", t_mul_init, 1);
         chk("to_operands", {t_mul_a, t_mul_b}, (op == 0) ? {t_req_a[7:0], t_req_b[7:0]}
                                                         : {t_req_a[15:8], t_req_b[15:8]});
         t_req_valid = 4'b0;
         t = 0;
         while (t_resp_valid === 4'b0 && t < 50) begin @(negedge clk); t++; end
         chk("to_latency", t, 9);
         chk("to_valid", t_resp_valid, (op == 0) ? 4'b0001 : 4'b0010);
         chk("to_error", t_resp_error, 1);
         chk("to_product", t_resp_product, 0);
         t_resp_ready = t_resp_valid;
         @(negedge clk);
         t_resp_ready = 4'b0;
         chk("to_ack", {t_busy, t_resp_valid, t_resp_error}, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mult_rr_scheduler.md
MULT_RR_SCHEDULER -- requirements
Module: mult_rr_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning operand width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles before abort (1..255).
REQ-004 The block SHALL have port clk, input, 1, system clock, all logic on its rising edge.
REQ-005 The block SHALL have port reset_L, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, NREQ, per-requester request strobe, held until accepted.
REQ-007 The block SHALL have port req_ready, output, NREQ, one-hot acceptance pulse.
REQ-008 The block SHALL have port req_a, input, NREQ*N, multiplicand operands; requester i occupies slice [i*N +: N].
REQ-009 The block SHALL have port req_b, input, NREQ*N, multiplier operands, sliced as req_a.
REQ-010 The block SHALL have port resp_valid, output, NREQ, one-hot result-available indication.
REQ-011 The block SHALL have port resp_ready, input, NREQ, per-requester result consume.
REQ-012 The block SHALL have port resp_product, output, 2N, result shared by all requesters.
REQ-013 The block SHALL have port resp_error, output, 1, qualifies resp_valid: the result is a timeout abort and product is zero.
REQ-014 The block SHALL have port mul_init, output, 1, start strobe to the multiplier.
REQ-015 The block SHALL have port mul_multiplicand, output, N, latched operand A.
REQ-016 The block SHALL have port mul_multiplier, output, N, latched operand B.
REQ-017 The block SHALL have port mul_idle, input, 1, multiplier idle flag.
REQ-018 The block SHALL have port mul_valid, input, 1, multiplier product-valid flag.
REQ-019 The block SHALL have port mul_product, input, 2N, multiplier product.
REQ-020 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-021 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-022 IDLE SHALL behave as follows: when mul_idle=1 and req_valid is non-zero, grant the first set bit at or after rr_ptr, searching upward with wrap.
REQ-023 On a grant, req_ready[g] SHALL pulse high for exactly one cycle, operands SHALL be latched into mul_multiplicand and mul_multiplier, g SHALL be stored, and the FSM SHALL go to ISSUE.
REQ-024 In IDLE with mul_idle=0, the block SHALL grant nothing and req_ready SHALL stay 0.
REQ-025 In ISSUE, mul_init SHALL be 1 for exactly one cycle, the timeout counter SHALL clear, and the FSM SHALL go to WAIT.
REQ-026 In WAIT, mul_valid=1 SHALL latch mul_product into resp_product, clear resp_error, and move the FSM to RESP.
REQ-027 In WAIT, each cycle without mul_valid SHALL increment the counter; when the counter equals TIMEOUT, the block SHALL set resp_error=1, set resp_product to 0, and move the FSM to RESP.
REQ-028 In RESP, resp_valid[g] SHALL be 1 and all other bits SHALL be 0; the outputs SHALL hold stable until resp_ready[g]=1.
REQ-029 When resp_ready[g]=1 in RESP, the block SHALL set rr_ptr to (g+1) mod NREQ, clear resp_valid, and return to IDLE in the same edge.
REQ-030 resp_ready bits other than g SHALL be ignored.
REQ-031 mul_valid outside WAIT SHALL be ignored.
REQ-032 Minimum latency from acceptance to resp_valid SHALL be 3 cycles (ISSUE, WAIT, then RESP) plus the multiplier compute time.
REQ-033 Throughput SHALL be one operation in flight at a time; no request is accepted while busy=1.
REQ-034 Simultaneous requests SHALL be served strictly round-robin, so each requester waits at most NREQ-1 operations.
REQ-035 rr_ptr SHALL wrap from NREQ-1 to 0.
REQ-036 A req_valid deasserted before acceptance SHALL be treated as withdrawn and never granted.
REQ-037 Operands SHALL be sampled only in the grant cycle; later changes to req_a or req_b SHALL have no effect on the operation in flight.
REQ-038 The product SHALL pass through unmodified, with the full 2N bits and signedness defined by the multiplier.

Reset
REQ-039 When reset_L=0, asynchronously: the FSM SHALL be IDLE, and rr_ptr, the stored grant and the timeout counter SHALL be 0.
REQ-040 When reset_L=0, asynchronously: req_ready, resp_valid, resp_error, mul_init and busy SHALL be 0, and mul_multiplicand, mul_multiplier and resp_product SHALL be 0.
REQ-041 Reset mid-operation SHALL abandon the operation with no response issued; any multiplier result arriving after reset SHALL be ignored until a new ISSUE.
REQ-042 After reset release, the first grant SHALL be evaluated on the first rising edge with reset_L=1.

Verification
REQ-043 Single request: req 1 valid with A=3, B=-5, multiplier model returns after 66 cycles -> req_ready[1] pulse, one mul_init pulse, resp_valid=4'b0010, resp_product=-15 (2N-bit), resp_error=0.
REQ-044 Contention: all 4 request continuously with rr_ptr=0 -> grant order 0,1,2,3,0; exactly one req_ready per operation.
REQ-045 Backpressure: resp_ready held 0 for 10 cycles in RESP -> resp_valid and resp_product stable; no new grant until resp_ready[g]=1.
REQ-046 Timeout: TIMEOUT=8, multiplier never asserts mul_valid -> resp_valid[g]=1 with resp_error=1 and resp_product=0 at 8 WAIT cycles; next grant proceeds normally.
REQ-047 Reset in WAIT: reset_L low for 2 cycles, then mul_valid arrives -> no resp_valid; busy=0; rr_ptr=0.
REQ-048 mul_idle=0 with req_valid=4'b0001 -> no req_ready until mul_idle=1, then grant on that edge.
